// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage load/store sequencer: hands one word access at a time to a req/ack data memory,
// stalls the pipeline while it is outstanding and reports misaligned, illegal or timed-out accesses.
module mem_stage_access_ctrl #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_memRead,
   input  logic          i_memWrite,
   input  logic          i_flush,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   output logic          o_stall,
   output logic [DW-1:0] o_rdata,
   output logic          o_rdata_valid,
   output logic          o_err
);

   // state | meaning
   // IDLE  | waiting for a MEM-stage access; illegal/misaligned ones flagged here
   // BUSY  | o_mem_req held, waiting for i_mem_ack or the timeout
   // DONE  | one-cycle release of the stall; load data / error strobes presented

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [TW-1:0] tmr;
   logic          discard_q;

   logic one_op;
   logic aligned;
   logic req_ok;
   logic req_bad;

   assign one_op  = i_memRead ^ i_memWrite;
   assign aligned = (i_addr[1:0] == 2'b00);
   assign req_ok  = one_op & ~i_flush & aligned;
   assign req_bad = ~i_flush & ((i_memRead & i_memWrite) | (one_op & ~aligned));

   // Gated by reset so the pipeline is released at once when reset lands mid-access.
   assign o_stall = i_rst_n & ((state == BUSY) | ((state == IDLE) & req_ok));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         tmr           <= '0;
         discard_q     <= 1'b0;
         o_mem_req     <= 1'b0;
         o_mem_we      <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_wdata   <= '0;
         o_rdata       <= '0;
         o_rdata_valid <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         o_rdata_valid <= 1'b0;
         o_err         <= 1'b0;
         case (state)
            IDLE: begin
               discard_q <= 1'b0;
               if (req_ok) begin
                  state       <= BUSY;
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= i_memWrite;
                  o_mem_addr  <= i_addr;
                  o_mem_wdata <= i_wdata;
                  tmr         <= TW'(TIMEOUT - 1);
               end else if (req_bad) begin
                  o_err <= 1'b1;
               end
            end
            BUSY: begin
               if (i_mem_ack) begin
                  state     <= DONE;
                  o_mem_req <= 1'b0;
                  tmr       <= '0;
                  if (!o_mem_we) begin
                     o_rdata       <= i_mem_rdata;
                     o_rdata_valid <= ~(discard_q | i_flush);
                  end
               end else if (tmr == '0) begin
                  state     <= DONE;
                  o_mem_req <= 1'b0;
                  o_err     <= 1'b1;
                  o_rdata   <= '0;
               end else begin
                  tmr <= tmr - 1'b1;
                  if (i_flush) discard_q <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: scenario tasks with a scoreboard of expected
// rdata_valid / err strobes, consumed as the controller produces them.
module tb_mem_stage_access_ctrl;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_memRead;
   logic          i_memWrite;
   logic          i_flush;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata;
   logic          i_mem_ack;
   logic [DW-1:0] i_mem_rdata;
   logic          o_mem_req;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic          o_stall;
   logic [DW-1:0] o_rdata;
   logic          o_rdata_valid;
   logic          o_err;

   typedef struct {
      logic          err;
      logic          valid;
      logic          chk_data;
      logic [DW-1:0] data;
   } ev_t;

   ev_t exp_q[$];
   ev_t got_ev;

   int checks   = 0;
   int failures = 0;

   int obs_stall;
   int obs_req;
   int obs_unstable;
   int obs_valid_cyc;
   int obs_done_cyc;

   mem_stage_access_ctrl #(
      .AW(AW),
      .DW(DW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_memRead(i_memRead),
      .i_memWrite(i_memWrite),
      .i_flush(i_flush),
      .i_addr(i_addr),
      .i_wdata(i_wdata),
      .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata),
      .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata),
      .o_stall(o_stall),
      .o_rdata(o_rdata),
      .o_rdata_valid(o_rdata_valid),
      .o_err(o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic clear_inputs();
      i_memRead   = 1'b0;
      i_memWrite  = 1'b0;
      i_flush     = 1'b0;
      i_addr      = '0;
      i_wdata     = '0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
   endtask

   // Drives one MEM-stage access for ncyc cycles (cycle 0 = presentation in IDLE),
   // holds the control until the stall releases, records what was seen and
   // retires strobes against the scoreboard.
   task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic fl0, input int ack_k,
                             input logic [DW-1:0] ack_data, input int flush_k, input int ncyc);
      bit released;
      released      = 1'b0;
      obs_stall     = 0;
      obs_req       = 0;
      obs_unstable  = 0;
      obs_valid_cyc = -1;
      obs_done_cyc  = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge i_clk);
         #1;
         if (c == 0) begin
            i_memRead  = rd;
            i_memWrite = wr;
            i_addr     = a;
            i_wdata    = wd;
            i_flush    = fl0;
         end else begin
            i_flush = (c == flush_k);
         end
         if (released) begin
            i_memRead  = 1'b0;
            i_memWrite = 1'b0;
            i_addr     = '0;
            i_wdata    = '0;
         end
         i_mem_ack   = (c == ack_k);
         i_mem_rdata = (c == ack_k) ? ack_data : 32'h0BAD0BAD;
         @(negedge i_clk);
         if (o_stall) obs_stall++;
         if (o_mem_req) begin
            obs_req++;
            if (o_mem_we !== wr || o_mem_addr !== a || o_mem_wdata !== wd) obs_unstable++;
         end
         if (!released && !o_stall && (c == 0 || obs_stall > 0)) begin
            released = 1'b1;
            if (c > 0) obs_done_cyc = c;
         end
         if (o_rdata_valid) obs_valid_cyc = c;
         if (o_err || o_rdata_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_strobe cyc=%0d err=%0b valid=%0b rdata=%h required no strobe",
                        c, o_err, o_rdata_valid, o_rdata);
            end else begin
               got_ev = exp_q.pop_front();
               if (o_err !== got_ev.err || o_rdata_valid !== got_ev.valid ||
                   (got_ev.chk_data && o_rdata !== got_ev.data)) begin
                  failures++;
                  $display("FAIL strobe cyc=%0d err=%0b valid=%0b rdata=%h required err=%0b valid=%0b rdata=%h",
                           c, o_err, o_rdata_valid, o_rdata, got_ev.err, got_ev.valid, got_ev.data);
               end
            end
         end
      end
      clear_inputs();
   endtask

   task automatic check_run(input string name, input int stall_e, input int req_e,
                            input int done_e, input int valid_e);
      checks++;
      if (obs_stall !== stall_e || obs_req !== req_e || obs_unstable !== 0 ||
          obs_done_cyc !== done_e || obs_valid_cyc !== valid_e) begin
         failures++;
         $display("FAIL %s stall=%0d req=%0d unstable=%0d done=%0d valid=%0d required stall=%0d req=%0d unstable=0 done=%0d valid=%0d",
                  name, obs_stall, obs_req, obs_unstable, obs_done_cyc, obs_valid_cyc,
                  stall_e, req_e, done_e, valid_e);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL %s_strobes pending=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      clear_inputs();
      #12;
      checks++;
      if ({o_mem_req, o_stall, o_err, o_rdata_valid, o_mem_we} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags req=%0b stall=%0b err=%0b valid=%0b we=%0b required all 0",
                  o_mem_req, o_stall, o_err, o_rdata_valid, o_mem_we);
      end
      checks++;
      if (o_rdata !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
         failures++;
         $display("FAIL reset_data rdata=%h addr=%h wdata=%h required 0", o_rdata, o_mem_addr, o_mem_wdata);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_load();
      exp_q.push_back('{err: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 32'hDEADBEEF});
      run_access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 3, 32'hDEADBEEF, -1, 10);
      check_run("load_ack3", 4, 3, 4, 4);
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b0, 1, 32'h0, -1, 8);
      check_run("store_ack1", 2, 1, 2, -1);
      checks++;
      if (o_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rdata_hold_after_store rdata=%h required %h", o_rdata, 32'hDEADBEEF);
      end
   endtask

   task automatic test_illegal();
      exp_q.push_back('{err: 1'b1, valid: 1'b0, chk_data: 1'b0, data: '0});
      run_access(1'b1, 1'b0, 32'h102, 32'h0, 1'b0, -1, 32'h0, -1, 5);
      check_run("load_misaligned", 0, 0, -1, -1);
      exp_q.push_back('{err: 1'b1, valid: 1'b0, chk_data: 1'b0, data: '0});
      run_access(1'b0, 1'b1, 32'h203, 32'h5, 1'b0, -1, 32'h0, -1, 5);
      check_run("store_misaligned", 0, 0, -1, -1);
      exp_q.push_back('{err: 1'b1, valid: 1'b0, chk_data: 1'b0, data: '0});
      run_access(1'b1, 1'b1, 32'h200, 32'h5, 1'b0, -1, 32'h0, -1, 5);
      check_run("read_and_write", 0, 0, -1, -1);
      run_access(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, -1, 32'h0, -1, 5);
      check_run("flush_in_idle", 0, 0, -1, -1);
      run_access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1, 32'h55, -1, 4);
      check_run("stray_ack", 0, 0, -1, -1);
      checks++;
      if (o_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rdata_hold_after_errors rdata=%h required %h", o_rdata, 32'hDEADBEEF);
      end
   endtask

   task automatic test_timeout();
      exp_q.push_back('{err: 1'b1, valid: 1'b0, chk_data: 1'b1, data: '0});
      run_access(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, -1, 32'h0, -1, TIMEOUT + 8);
      check_run("timeout", TIMEOUT + 1, TIMEOUT, TIMEOUT + 1, -1);
      checks++;
      if (o_rdata !== '0) begin
         failures++;
         $display("FAIL timeout_rdata rdata=%h required 0", o_rdata);
      end
   endtask

   task automatic test_flush_busy();
      run_access(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 4, 32'hAAAA5555, 2, 10);
      check_run("flush_in_busy", 5, 4, 5, -1);
   endtask

   task automatic test_reset_mid();
      @(posedge i_clk);
      #1;
      i_memRead = 1'b1;
      i_addr    = 32'h108;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      checks++;
      if (o_mem_req !== 1'b1 || o_stall !== 1'b1) begin
         failures++;
         $display("FAIL midreset_pre req=%0b stall=%0b required req=1 stall=1", o_mem_req, o_stall);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
         failures++;
         $display("FAIL midreset_drop req=%0b stall=%0b required req=0 stall=0", o_mem_req, o_stall);
      end
      clear_inputs();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      exp_q.push_back('{err: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 32'h0F0F1234});
      run_access(1'b1, 1'b0, 32'h10C, 32'h0, 1'b0, 2, 32'h0F0F1234, -1, 8);
      check_run("load_after_reset", 3, 2, 3, 3);
   endtask

   task automatic test_back_to_back();
      exp_q.push_back('{err: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 32'h11112222});
      run_access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1, 32'h11112222, -1, 3);
      check_run("b2b_load1", 2, 1, 2, 2);
      run_access(1'b0, 1'b1, 32'h404, 32'hCAFEF00D, 1'b0, 2, 32'h0, -1, 4);
      check_run("b2b_store", 3, 2, 3, -1);
      exp_q.push_back('{err: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 32'h33334444});
      run_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0, 1, 32'h33334444, -1, 5);
      check_run("b2b_load2", 2, 1, 2, 2);
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_illegal();
      test_timeout();
      test_flush_busy();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
